i2s_tx: RTL and testbench

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/audio_pkg.sv | 10 +
 rtl/i2s_sck_gen.sv | 39 +++
 rtl/i2s_tx.sv | 94 +++++++++
 tb/tb_i2s_tx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions: I2S default geometry and transmitter state encoding.
package audio_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int CLK_DIV_DEF    = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } i2s_state_e;
endpackage

// File: rtl/i2s_sck_gen.sv
// Bit-clock divider: sck toggles every CLK_DIV clk while run is high.
// fall_pulse marks the clk whose closing edge takes sck from 1 to 0.
module i2s_sck_gen
  import audio_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic sck,
  output logic fall_pulse
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_div;
  logic          r_sck;
  logic          w_wrap;

  assign w_wrap = run && (r_div == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
      r_sck <= 1'b0;
    end else if (!run) begin
      r_div <= '0;
      r_sck <= 1'b0;
    end else if (w_wrap) begin
      r_div <= '0;
      r_sck <= ~r_sck;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign sck        = r_sck;
  assign fall_pulse = w_wrap & r_sck;
endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-deep sample-pair holding register feeding a {left,right}
// shift register; ws/sd change on sck falling edges, MSB one slot after ws.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CLK_DIV    = CLK_DIV_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] s_left,
  input  logic [DATA_WIDTH-1:0] s_right,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  sck,
  output logic                  ws,
  output logic                  sd,
  output logic                  underrun
);
  localparam int FW = 2 * DATA_WIDTH;
  localparam int SW = $clog2(FW);

  i2s_state_e     r_state;
  logic [FW-1:0]  r_hold;
  logic           r_full;
  logic           r_s_ready;
  logic [FW-1:0]  r_shift;
  logic [SW-1:0]  r_slot;
  logic           r_ws;
  logic           r_sd;
  logic           r_underrun;

  logic           w_run;
  logic           w_fall;
  logic           w_accept;
  logic           w_entry;
  logic           w_load;
  logic           w_step;
  logic           w_full_nxt;
  logic [SW-1:0]  w_slot_nxt;

  assign w_run    = (r_state == ST_RUN);
  assign w_accept = s_valid & r_s_ready;

  i2s_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (w_run),
    .sck        (sck),
    .fall_pulse (w_fall)
  );

  // The IDLE->RUN clk is itself a slot-0 load; later loads follow the last slot.
  assign w_entry    = (r_state == ST_IDLE) & r_full;
  assign w_load     = w_entry | (w_fall & (r_slot == SW'(FW - 1)));
  assign w_step     = w_load | w_fall;
  assign w_slot_nxt = w_load ? '0 : r_slot + 1'b1;
  // A load drains the old content before a coinciding accept refills it.
  assign w_full_nxt = w_accept | (r_full & ~w_load);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_hold     <= '0;
      r_full     <= 1'b0;
      r_s_ready  <= 1'b1;
      r_shift    <= '0;
      r_slot     <= '0;
      r_ws       <= 1'b0;
      r_sd       <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_load & ~r_full;
      r_full     <= w_full_nxt;
      r_s_ready  <= ~w_full_nxt;
      if (w_accept) r_hold <= {s_left, s_right};
      if (w_entry) r_state <= ST_RUN;
      if (w_step) begin
        r_slot  <= w_slot_nxt;
        r_ws    <= (w_slot_nxt >= SW'(DATA_WIDTH));
        // After 2W-1 shifts the MSB holds the old right LSB for the next slot 0.
        r_sd    <= r_shift[FW-1];
        r_shift <= w_load ? (r_full ? r_hold : '0) : (r_shift << 1);
      end
    end
  end

  assign s_ready  = r_s_ready;
  assign ws       = r_ws;
  assign sd       = r_sd;
  assign underrun = r_underrun;
endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx (DATA_WIDTH=16, CLK_DIV=2): frame-timing model, I2S receiver
// monitor and expected-frame queue.
module tb_i2s_tx;
  localparam int DW    = 16;
  localparam int CD    = 2;
  localparam int FW    = 2 * DW;
  localparam int FRAME = FW * 2 * CD;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] s_left = '0;
  logic [DW-1:0] s_right = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          sck;
  logic          ws;
  logic          sd;
  logic          underrun;

  i2s_tx #(
    .DATA_WIDTH (DW),
    .CLK_DIV    (CD)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_left   (s_left),
    .s_right  (s_right),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .sck      (sck),
    .ws       (ws),
    .sd       (sd),
    .underrun (underrun)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model of holding register and frame timing
  logic [FW-1:0] exp_q[$];
  bit            m_run = 1'b0;
  bit            m_full = 1'b0;
  bit            m_ur_exp = 1'b0;
  int            m_cnt = 0;
  logic [FW-1:0] m_hold = '0;

  initial begin
    bit load;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_run = 1'b0; m_full = 1'b0; m_ur_exp = 1'b0; m_cnt = 0;
        exp_q.delete();
      end else begin
        chk("ready", 64'(s_ready), 64'(!m_full));
        load = m_run ? (m_cnt == FRAME - 1) : m_full;
        m_ur_exp = 1'b0;
        if (m_run) m_cnt = m_cnt + 1;
        if (load) begin
          exp_q.push_back(m_full ? m_hold : '0);
          m_ur_exp = !m_full;
          m_full   = 1'b0;
          m_run    = 1'b1;
          m_cnt    = 0;
        end
        if (s_valid && s_ready) begin
          m_hold = {s_left, s_right};
          m_full = 1'b1;
        end
      end
    end
  end

  // receiver monitor and per-clk line checks, sampled on the falling clk edge
  int            rise_cnt = 0;
  logic          sck_q = 1'b0;
  logic          prev_lsb = 1'b0;
  logic [FW-1:0] sd_w = '0;
  logic [FW-1:0] ws_w = '0;
  int            frames_seen = 0;

  initial begin
    int            slot;
    logic [FW-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rise_cnt = 0; sck_q = 1'b0; prev_lsb = 1'b0;
      end else begin
        chk("underrun", 64'(underrun), 64'(m_ur_exp));
        chk("sck", 64'(sck), 64'(m_run && ((m_cnt / CD) % 2 == 1)));
        if (!m_run) chk("idle_line", 64'({ws, sd}), 64'd0);
        if (sck && !sck_q) begin
          slot = rise_cnt % FW;
          sd_w[FW-1-slot] = sd;
          ws_w[FW-1-slot] = ws;
          rise_cnt++;
          if (slot == FW - 1) begin
            chk("exp_avail", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("frame_sd", 64'(sd_w), 64'({prev_lsb, e[FW-1:1]}));
              chk("frame_ws", 64'(ws_w), 64'h0000_FFFF);
              prev_lsb = e[0];
              frames_seen++;
            end
          end
        end
        sck_q = sck;
      end
    end
  end

  // driver tasks
  task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    bit acc = 1'b0;
    int n = 0;
    s_left = l; s_right = r; s_valid = 1'b1;
    while (!acc && n < 2000) begin
      @(posedge clk);
      acc = s_ready;
      n++;
    end
    chk("accept_wait", 64'(acc), 64'd1);
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_cnt(input int c);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < 2000) begin
      @(posedge clk);
      #1;
      hit = m_run && (m_cnt == c);
      n++;
    end
    chk("slot_wait", 64'(hit), 64'd1);
  endtask

  // valid raised for exactly the clk that ends in a slot-0 load
  task automatic send_at_load(input logic [DW-1:0] l, input logic [DW-1:0] r);
    wait_cnt(FRAME - 1);
    chk("hold_empty", 64'(s_ready), 64'd1);
    s_left = l; s_right = r; s_valid = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1;
    chk("rst_ready", 64'(s_ready), 64'd1);
    chk("rst_lines", 64'({sck, ws, sd, underrun}), 64'd0);
    reset_n = 1'b1;
    repeat (200) @(posedge clk);
    #1;

    // single pair, then an underrun frame carrying the right LSB in slot 0
    send_pair(16'hA5A5, 16'h0F0F);
    repeat (300) @(posedge clk);
    #1;

    // accept coinciding with an empty-holding load
    send_at_load(16'h1234, 16'h8001);

    // back-to-back streaming
    for (int i = 0; i < 3; i++)
      send_pair(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
    repeat (5 * FRAME) @(posedge clk);
    #1;

    // reset in slot 10 of a data frame
    send_pair(16'hC3C3, 16'h5A5A);
    wait_cnt(FRAME - 1);
    wait_cnt(41);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(s_ready), 64'd1);
    chk("mid_rst_lines", 64'({sck, ws, sd, underrun}), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;

    send_pair(16'h7FFF, 16'h8000);
    repeat (2 * FRAME + 10) @(posedge clk);
    #1;
    chk("frames_seen_min", 64'(frames_seen >= 12), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
